// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate L1 data cache.
// RV32 byte/half/word load extract and store merge; 128-bit line refill/evict.
module data_cache #(
    parameter int BLOCKS = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   READ,
    input  logic [2:0]   WRITE,
    input  logic [31:0]  ADDR,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    localparam int IW = $clog2(BLOCKS);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FETCH,
        S_UPDATE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [BLOCKS-1:0] r_valid;
    logic [BLOCKS-1:0] r_dirty;
    logic [TW-1:0]     r_tag  [BLOCKS];
    logic [127:0]      r_data [BLOCKS];
    logic [127:0]      r_fill;

    logic [IW-1:0] w_index;
    logic [TW-1:0] w_tag;
    logic          w_load;
    logic          w_store;
    logic          w_access;
    logic          w_hit;
    logic          w_store_hit;
    logic [127:0]  w_line;
    logic [31:0]   w_word;
    logic [15:0]   w_half;
    logic [7:0]    w_byte;
    logic [31:0]   w_rdata;
    logic [15:0]   w_wmask;
    logic [127:0]  w_wrep;
    logic [127:0]  w_merged;

    assign w_index  = ADDR[4+IW-1:4];
    assign w_tag    = ADDR[31:4+IW];
    assign w_store  = WRITE[2];
    assign w_load   = READ[3] & ~WRITE[2];
    assign w_access = READ[3] | WRITE[2];
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);

    assign w_store_hit = (r_state == S_IDLE) & w_store & w_hit;

    assign w_line = r_data[w_index];
    assign w_word = w_line[{ADDR[3:2], 5'd0} +: 32];
    assign w_half = w_word[{ADDR[1], 4'd0} +: 16];
    assign w_byte = w_word[{ADDR[1:0], 3'd0} +: 8];

    // Load extraction; no hit or no load returns zero
    always_comb begin
        w_rdata = '0;
        if (w_load && w_hit) begin
            case (READ[2:0])
                3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
                3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
                3'b010:  w_rdata = w_word;
                3'b100:  w_rdata = {24'd0, w_byte};
                3'b101:  w_rdata = {16'd0, w_half};
                default: w_rdata = '0;
            endcase
        end
    end

    assign READDATA = w_rdata;
    assign BUSYWAIT = (r_state != S_IDLE) | (w_access & ~w_hit);

    // Store merge: replicate the data, then pick lanes with a byte mask
    always_comb begin
        w_wmask = '0;
        w_wrep  = '0;
        case (WRITE[1:0])
            2'b00: begin
                w_wmask = 16'h0001 << ADDR[3:0];
                w_wrep  = {16{WRITEDATA[7:0]}};
            end
            2'b01: begin
                w_wmask = 16'h0003 << {ADDR[3:1], 1'b0};
                w_wrep  = {8{WRITEDATA[15:0]}};
            end
            2'b10: begin
                w_wmask = 16'h000F << {ADDR[3:2], 2'b00};
                w_wrep  = {4{WRITEDATA}};
            end
            default: begin
                w_wmask = '0;
                w_wrep  = '0;
            end
        endcase
        w_merged = w_line;
        for (int b = 0; b < 16; b++) begin
            if (w_wmask[b]) begin
                w_merged[b*8 +: 8] = w_wrep[b*8 +: 8];
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = ADDR[31:4];
        MEM_WRITEDATA = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_access && !w_hit) begin
                    w_next = r_dirty[w_index] ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {r_tag[w_index], w_index};
                MEM_WRITEDATA = w_line;
                if (!MEM_BUSYWAIT) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    w_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_UPDATE) begin
                r_valid[w_index] <= 1'b1;
                r_dirty[w_index] <= 1'b0;
            end else if (w_store_hit) begin
                r_dirty[w_index] <= 1'b1;
            end
        end
    end

    // Line storage is never cleared; valid bits gate it
    always_ff @(posedge CLK) begin
        if (r_state == S_FETCH && !MEM_BUSYWAIT) begin
            r_fill <= MEM_READDATA;
        end
        if (r_state == S_UPDATE) begin
            r_data[w_index] <= r_fill;
            r_tag[w_index]  <= w_tag;
        end else if (w_store_hit) begin
            r_data[w_index] <= w_merged;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Randomised bench for data_cache: a flat byte-addressed memory view and
// a per-index residency table predict load data, stalls and evictions.
module tb_data_cache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [3:0]   READ = '0;
    logic [2:0]   WRITE = '0;
    logic [31:0]  ADDR = '0;
    logic [31:0]  WRITEDATA = '0;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA = '0;
    logic         MEM_BUSYWAIT = 1'b0;

    data_cache #(.BLOCKS(8)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .READ(READ),
        .WRITE(WRITE),
        .ADDR(ADDR),
        .WRITEDATA(WRITEDATA),
        .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail = 0;

    // rmem: what a CPU should observe; mmem: backing main memory
    logic [127:0] rmem [logic [27:0]];
    logic [127:0] mmem [logic [27:0]];

    logic [24:0] mtag [8];
    bit          mval [8];
    bit          mdir [8];

    int           mem_lat = 0;
    int           mcnt = 0;
    int           wb_cnt = 0;
    logic [127:0] last_wb = '0;
    logic [27:0]  exp_wb_blk = '0;
    logic [31:0]  last_rd;
    int           last_busy;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ensure(input logic [27:0] b);
        logic [127:0] v;
        if (!rmem.exists(b)) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            rmem[b] = v;
            mmem[b] = v;
        end
    endtask

    function automatic logic [7:0] rb(input logic [31:0] a);
        logic [127:0] b;
        b = rmem[a[31:4]];
        return b[{a[3:0], 3'd0} +: 8];
    endfunction

    task automatic wbyte(input logic [31:0] a, input logic [7:0] v);
        logic [127:0] b;
        b = rmem[a[31:4]];
        b[{a[3:0], 3'd0} +: 8] = v;
        rmem[a[31:4]] = b;
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] a);
        logic [31:0] ah;
        logic [31:0] aw;
        logic [15:0] h;
        logic [7:0]  by;
        ah = {a[31:1], 1'b0};
        aw = {a[31:2], 2'b00};
        by = rb(a);
        h  = {rb(ah + 1), rb(ah)};
        case (f3)
            3'b000:  return {{24{by[7]}}, by};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return {rb(aw + 3), rb(aw + 2), rb(aw + 1), rb(aw)};
            3'b100:  return {24'd0, by};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_store(input logic [1:0] f, input logic [31:0] a,
                             input logic [31:0] d);
        logic [31:0] ah;
        logic [31:0] aw;
        ah = {a[31:1], 1'b0};
        aw = {a[31:2], 2'b00};
        case (f)
            2'b00: wbyte(a, d[7:0]);
            2'b01: begin
                wbyte(ah, d[7:0]);
                wbyte(ah + 1, d[15:8]);
            end
            2'b10: begin
                for (int k = 0; k < 4; k++) wbyte(aw + k, d[k*8 +: 8]);
            end
            default: ;
        endcase
    endtask

    // Main memory: mem_lat busy cycles, then completes the held request
    always @(negedge CLK) begin
        if (MEM_READ || MEM_WRITE) begin
            if (mcnt < mem_lat) begin
                MEM_BUSYWAIT = 1'b1;
                mcnt++;
            end else begin
                MEM_BUSYWAIT = 1'b0;
                mcnt = 0;
                check("mem_excl", MEM_READ & MEM_WRITE, 1'b0);
                ensure(MEM_ADDRESS);
                if (MEM_WRITE) begin
                    check("wb_addr", MEM_ADDRESS, exp_wb_blk);
                    check("wb_data", MEM_WRITEDATA, rmem[MEM_ADDRESS]);
                    mmem[MEM_ADDRESS] = MEM_WRITEDATA;
                    last_wb = MEM_WRITEDATA;
                    wb_cnt++;
                end else begin
                    check("fetch_addr", MEM_ADDRESS, ADDR[31:4]);
                    MEM_READDATA = mmem[MEM_ADDRESS];
                end
            end
        end else begin
            MEM_BUSYWAIT = 1'b0;
            mcnt = 0;
        end
    end

    task automatic op(input logic [3:0] rd, input logic [2:0] wr,
                      input logic [31:0] a, input logic [31:0] wd);
        int          idx;
        logic [24:0] tg;
        bit          hit;
        int          exp_busy;
        logic [31:0] exp_rd;
        int          busy;
        ensure(a[31:4]);
        idx = int'(a[6:4]);
        tg = a[31:7];
        hit = mval[idx] && (mtag[idx] == tg);
        if (hit) exp_busy = 0;
        else if (mdir[idx]) exp_busy = 2 * mem_lat + 4;
        else exp_busy = mem_lat + 3;
        exp_wb_blk = {mtag[idx], a[6:4]};
        exp_rd = wr[2] ? 32'd0 : (rd[3] ? ref_load(rd[2:0], a) : 32'd0);
        @(negedge CLK);
        READ = rd;
        WRITE = wr;
        ADDR = a;
        WRITEDATA = wd;
        #1;
        busy = 0;
        while (BUSYWAIT && busy < 500) begin
            @(negedge CLK);
            #1;
            busy++;
        end
        last_rd = READDATA;
        last_busy = busy;
        check("stall", busy, exp_busy);
        check("rdata", READDATA, exp_rd);
        @(posedge CLK);
        if (!hit) begin
            mval[idx] = 1'b1;
            mtag[idx] = tg;
            mdir[idx] = 1'b0;
        end
        if (wr[2]) begin
            mdir[idx] = 1'b1;
            ref_store(wr[1:0], a, wd);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          k;
        int          n;
        int          wb_before;
        for (int i = 0; i < 8; i++) begin
            mval[i] = 1'b0;
            mdir[i] = 1'b0;
            mtag[i] = '0;
        end
        repeat (2) @(negedge CLK);
        #1;
        check("rst_busy", BUSYWAIT, 1'b0);
        check("rst_rdata", READDATA, 32'd0);
        check("rst_mread", MEM_READ, 1'b0);
        check("rst_mwrite", MEM_WRITE, 1'b0);
        RESET = 1'b1;

        rmem[28'h4] = {32'h3333_3333, 32'h2222_2222,
                       32'hDEAD_BEEF, 32'h1111_1111};
        mmem[28'h4] = rmem[28'h4];
        mem_lat = 5;
        op(4'b1010, 3'b000, 32'h44, 32'd0);
        check("lw44_miss_data", last_rd, 32'hDEAD_BEEF);
        check("lw44_miss_stall", last_busy, 8);
        op(4'b1010, 3'b000, 32'h44, 32'd0);
        check("lw44_hit_stall", last_busy, 0);
        op(4'b0000, 3'b100, 32'h45, 32'h80);
        op(4'b1000, 3'b000, 32'h45, 32'd0);
        check("lb45", last_rd, 32'hFFFF_FF80);
        op(4'b1100, 3'b000, 32'h45, 32'd0);
        check("lbu45", last_rd, 32'h0000_0080);
        op(4'b1001, 3'b000, 32'h46, 32'd0);
        check("lh46", last_rd, 32'hFFFF_DEAD);

        // Dirty eviction, then reset while the refill is outstanding
        ensure(28'hC);
        exp_wb_blk = 28'h4;
        wb_before = wb_cnt;
        @(negedge CLK);
        READ = 4'b1010;
        WRITE = 3'b000;
        ADDR = 32'hC4;
        #1;
        n = 0;
        while (!MEM_READ && n < 200) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("evict_fetch_seen", MEM_READ, 1'b1);
        check("evict_fetch_addr", MEM_ADDRESS, 28'hC);
        check("evict_wb_count", wb_cnt - wb_before, 1);
        check("evict_wb_word1", last_wb[63:32], 32'hDEAD_80EF);
        RESET = 1'b0;
        #1;
        check("rst_mid_mread", MEM_READ, 1'b0);
        check("rst_mid_mwrite", MEM_WRITE, 1'b0);
        READ = 4'b0000;
        #1;
        check("rst_mid_busy", BUSYWAIT, 1'b0);
        check("rst_mid_rdata", READDATA, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mval[i] = 1'b0;
            mdir[i] = 1'b0;
        end
        rmem = mmem;
        mem_lat = 2;
        op(4'b1010, 3'b000, 32'h44, 32'd0);
        check("post_rst_miss", last_busy, 5);
        check("post_rst_data", last_rd, 32'hDEAD_80EF);

        op(4'b1010, 3'b110, 32'h48, 32'h1234_5678);
        check("rdwr_rdata", last_rd, 32'd0);
        op(4'b1010, 3'b000, 32'h48, 32'd0);
        check("rdwr_lw48", last_rd, 32'h1234_5678);

        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            k = $urandom_range(0, 8);
            mem_lat = $urandom_range(0, 3);
            a = {r[31] ? 22'h2AF0C1 : 22'h0, r[9:0]};
            case (k)
                0: op(4'b1000, 3'b000, a, $urandom);
                1: op(4'b1001, 3'b000, a, $urandom);
                2: op(4'b1010, 3'b000, a, $urandom);
                3: op(4'b1100, 3'b000, a, $urandom);
                4: op(4'b1101, 3'b000, a, $urandom);
                5: op(4'b0000, 3'b100, a, $urandom);
                6: op(4'b0000, 3'b101, a, $urandom);
                7: op(4'b0000, 3'b110, a, $urandom);
                default: op(4'b1010, 3'b110, a, $urandom);
            endcase
        end
        @(negedge CLK);
        READ = 4'b0000;
        WRITE = 3'b000;
        repeat (2) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
